// File: rtl/pkt_axi_wr_master.sv
// AXIS byte stream to AXI4 INCR write bursts. Bytes are packed little-endian
// into 32-bit words, buffered up to BURST_BEATS words, then written out as
// AW -> W -> B. Reports packet byte length, completion and write errors.

package pkt_axi_pkg;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tvalid;
        logic       tlast;
    } s_axis_mosi_t;

    typedef struct packed {
        logic tready;
    } s_axis_miso_t;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
        logic [3:0] bid;
    } s_axi_miso_t;

endpackage

module pkt_axi_wr_master
    import pkt_axi_pkg::*;
#(
    parameter int unsigned BURST_BEATS = 16,
    parameter logic [3:0]  AXI_ID      = 4'd0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          clk_axi,
    input  logic          rst_axi,
    input  s_axis_mosi_t  axis_in_mosi,
    output s_axis_miso_t  axis_in_miso,
    output s_axi_mosi_t   axi_mosi,
    input  s_axi_miso_t   axi_miso,
    output logic [15:0]   pkt_len_o,
    output logic          done_o,
    output logic          err_o,
    output logic          busy_o
);

    localparam int unsigned WordW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

    typedef enum logic [1:0] {StFill, StAw, StW, StB} state_e;

    state_e           state_q;
    logic [31:0]      word_buf_q [BURST_BEATS];
    logic [1:0]       byte_cnt_q;
    logic [WordW-1:0] word_cnt_q;
    logic [WordW-1:0] beat_cnt_q;
    logic             last_ff_q;
    logic [3:0]       last_strb_q;
    logic [7:0]       awlen_q;
    logic             awvalid_q;
    logic             wvalid_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             wlast_q;
    logic             bready_q;
    logic             tready_q;
    logic             busy_q;
    logic             err_q;
    logic [15:0]      pkt_len_q;
    logic [15:0]      byte_total_q;

    logic             beat_acc;
    logic             buf_full;
    logic             b_acc;
    logic             b_err;
    logic [15:0]      total_inc;
    logic [WordW-1:0] next_beat;
    logic [3:0]       next_strb;
    logic [3:0]       lane_strb;
    logic             unused_bid;

    assign beat_acc  = axis_in_mosi.tvalid & tready_q;
    assign buf_full  = (byte_cnt_q == 2'd3) && (word_cnt_q == WordW'(BURST_BEATS - 1));
    assign b_acc     = bready_q & axi_miso.bvalid;
    assign b_err     = (axi_miso.bresp != 2'b00);
    // First byte of a packet restarts the count; otherwise saturating increment.
    assign total_inc = !busy_q ? 16'd1 :
                       (byte_total_q == 16'hFFFF) ? 16'hFFFF : byte_total_q + 16'd1;
    assign next_beat = beat_cnt_q + WordW'(1);
    assign next_strb = (last_ff_q && (8'(next_beat) == awlen_q)) ? last_strb_q : 4'hF;
    assign unused_bid = ^axi_miso.bid;

    // Strobe for a final word whose last valid byte sits in lane byte_cnt_q.
    always_comb begin
        lane_strb = 4'hF;
        unique case (byte_cnt_q)
            2'd0:    lane_strb = 4'b0001;
            2'd1:    lane_strb = 4'b0011;
            2'd2:    lane_strb = 4'b0111;
            default: lane_strb = 4'b1111;
        endcase
    end

    // Fill / address / data / response sequencing with registered channel outputs.
    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            state_q      <= StFill;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            last_ff_q    <= 1'b0;
            last_strb_q  <= '0;
            awlen_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            pkt_len_q    <= '0;
            byte_total_q <= '0;
            for (int i = 0; i < BURST_BEATS; i++) word_buf_q[i] <= '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    tready_q <= 1'b1;
                    if (beat_acc) begin
                        word_buf_q[word_cnt_q][{byte_cnt_q, 3'b000} +: 8] <= axis_in_mosi.tdata;
                        byte_total_q <= total_inc;
                        busy_q       <= 1'b1;
                        if (!busy_q) err_q <= 1'b0;
                        if (axis_in_mosi.tlast || buf_full) begin
                            // Counters stay on the final byte; they are cleared after B.
                            state_q     <= StAw;
                            tready_q    <= 1'b0;
                            awvalid_q   <= 1'b1;
                            awlen_q     <= 8'(word_cnt_q);
                            last_ff_q   <= axis_in_mosi.tlast;
                            last_strb_q <= lane_strb;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) word_cnt_q <= word_cnt_q + WordW'(1);
                        end
                    end
                end
                StAw: begin
                    if (axi_miso.awready) begin
                        awvalid_q  <= 1'b0;
                        wvalid_q   <= 1'b1;
                        wdata_q    <= word_buf_q[0];
                        wstrb_q    <= (last_ff_q && awlen_q == 8'd0) ? last_strb_q : 4'hF;
                        wlast_q    <= (awlen_q == 8'd0);
                        beat_cnt_q <= '0;
                        state_q    <= StW;
                    end
                end
                StW: begin
                    if (axi_miso.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= StB;
                        end else begin
                            beat_cnt_q <= next_beat;
                            wdata_q    <= word_buf_q[next_beat];
                            wstrb_q    <= next_strb;
                            wlast_q    <= (8'(next_beat) == awlen_q);
                        end
                    end
                end
                StB: begin
                    if (axi_miso.bvalid) begin
                        bready_q   <= 1'b0;
                        tready_q   <= 1'b1;
                        state_q    <= StFill;
                        err_q      <= err_q | b_err;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        beat_cnt_q <= '0;
                        for (int i = 0; i < BURST_BEATS; i++) word_buf_q[i] <= '0;
                        if (last_ff_q) begin
                            busy_q    <= 1'b0;
                            last_ff_q <= 1'b0;
                            pkt_len_q <= byte_total_q;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    // Completion is flagged in the cycle the final response is accepted.
    assign done_o    = b_acc & last_ff_q;
    assign pkt_len_o = done_o ? byte_total_q : pkt_len_q;
    assign err_o     = err_q | (b_acc & b_err);
    assign busy_o    = busy_q;

    assign axis_in_miso.tready = tready_q;

    // Drive AW/W/B fields; read channels are tied off.
    always_comb begin
        axi_mosi         = '0;
        axi_mosi.awid    = AXI_ID;
        axi_mosi.awaddr  = BASE_ADDR;
        axi_mosi.awlen   = awlen_q;
        axi_mosi.awsize  = 3'd2;
        axi_mosi.awburst = 2'b01;
        axi_mosi.awvalid = awvalid_q;
        axi_mosi.wdata   = wdata_q;
        axi_mosi.wstrb   = wstrb_q;
        axi_mosi.wlast   = wlast_q;
        axi_mosi.wvalid  = wvalid_q;
        axi_mosi.bready  = bready_q;
    end

endmodule
